// File: rtl/uart_loop_fifo_pkg.sv
// Shared definitions for the buffered UART loop stage: transform mode codes and FSM states.
package uart_loop_fifo_pkg;

   typedef enum logic [1:0] {
      ModePass  = 2'd0,
      ModeUpper = 2'd1,
      ModeInv   = 2'd2,
      ModeRev   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StWaitHi = 2'd2,
      StWaitLo = 2'd3
   } state_e;

endpackage

// File: rtl/uart_loop_fifo_if.sv
// Receiver-to-transmitter handshake bundle. The slave side is the loop stage;
// the master side is the surrounding receiver and transmitter.
interface uart_loop_if #(
   parameter int unsigned DATA_W = 8
) ();

   logic              recv_done;
   logic [DATA_W-1:0] recv_data;
   logic              tx_busy;
   logic              send_en;
   logic [DATA_W-1:0] send_data;

   modport master (
      output recv_done,
      output recv_data,
      output tx_busy,
      input  send_en,
      input  send_data
   );

   modport slave (
      input  recv_done,
      input  recv_data,
      input  tx_busy,
      output send_en,
      output send_data
   );

endinterface

// File: rtl/uart_loop_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count. A write while full is only
// accepted when a read frees the head slot in the same cycle.
module uart_loop_fifo_sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              wr_ok, rd_ok;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign wr_ok = wr_en & (~full | rd_en);
   assign rd_ok = rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CntW'(wr_ok) - CntW'(rd_ok);
      if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_loop_fifo.sv
// Buffered UART loop stage: queues received bytes, transforms each at launch and
// paces launches against the transmitter busy flag with a rise timeout.
module uart_loop_fifo
   import uart_loop_fifo_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned BUSY_TIMEOUT = 15
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   uart_loop_if.slave             bus,
   input  logic [1:0]             mode,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow,
   input  logic                   ovf_clr
);

   localparam int unsigned TmoW = $clog2(BUSY_TIMEOUT + 2);

   state_e            state_q, state_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              done_q;
   logic              send_en_q;
   logic [DATA_W-1:0] send_data_q;
   logic              overflow_q, overflow_d;

   logic              push, pop, drop;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d, input mode_e m);
      logic [DATA_W-1:0] r;
      r = d;
      unique case (m)
         ModeUpper: begin
            if (DATA_W == 8 && d >= DATA_W'(8'h61) && d <= DATA_W'(8'h7A)) begin
               r = d - DATA_W'(8'h20);
            end
         end
         ModeInv: r = ~d;
         ModeRev: begin
            for (int i = 0; i < int'(DATA_W); i++) r[i] = d[int'(DATA_W) - 1 - i];
         end
         default: r = d;
      endcase
      return r;
   endfunction

   assign push = bus.recv_done & ~done_q;
   assign pop  = (state_q == StLaunch);
   // A full FIFO still accepts the byte when the head is popped in the same cycle.
   assign drop = push & fifo_full & ~pop;

   uart_loop_fifo_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .wr_en   (push),
      .wr_data (bus.recv_data),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty && !bus.tx_busy) state_d = StLaunch;
         end
         StLaunch: begin
            state_d = StWaitHi;
            tmo_d   = '0;
         end
         StWaitHi: begin
            // A transmitter that never answers must not stall the queue forever.
            if (bus.tx_busy) begin
               state_d = StWaitLo;
            end else if (tmo_q == TmoW'(BUSY_TIMEOUT)) begin
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StWaitLo: begin
            if (!bus.tx_busy) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= StIdle;
         tmo_q       <= '0;
         done_q      <= 1'b0;
         send_en_q   <= 1'b0;
         send_data_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         done_q      <= bus.recv_done;
         send_en_q   <= pop;
         overflow_q  <= overflow_d;
         if (pop) send_data_q <= xform(fifo_head, mode_e'(mode));
      end
   end

   assign bus.send_en   = send_en_q;
   assign bus.send_data = send_data_q;
   assign overflow      = overflow_q;

endmodule
